// File: rtl/bolme_birimi_if.sv
// rtl/bolme_birimi_if.sv - request/result bundle of the iterative 32-bit divider
interface bolme_birimi_if;
    logic        istek_i;
    logic [1:0]  islem_i;
    logic [31:0] bolunen_i;
    logic [31:0] bolen_i;
    logic        iptal_i;
    logic [31:0] sonuc_o;
    logic        gecerli_o;
    logic        mesgul_o;

    modport master (
        output istek_i, islem_i, bolunen_i, bolen_i, iptal_i,
        input  sonuc_o, gecerli_o, mesgul_o
    );

    modport slave (
        input  istek_i, islem_i, bolunen_i, bolen_i, iptal_i,
        output sonuc_o, gecerli_o, mesgul_o
    );
endinterface

// File: rtl/bolme_birimi.sv
// rtl/bolme_birimi.sv - RV32M DIV/DIVU/REM/REMU restoring divider, one bit per clock
module bolme_birimi (
    input  logic              clk_i,
    input  logic              rst_i,
    bolme_birimi_if.slave     bb
);
    typedef enum logic {BOSTA, HESAPLA} durum_t;

    durum_t      durum_q, durum_d;
    logic        kalan_sec_q;          // 1: result is the remainder (REM/REMU)
    logic [31:0] bolum_q;              // dividend bits shift out MSB, quotient bits shift in LSB
    logic [31:0] bolen_q;
    logic [31:0] kalan_q;
    logic [5:0]  sayac_q;
    logic        bolunen_neg_q, bolen_neg_q;
    logic [31:0] sonuc_q;
    logic        gecerli_q;

    logic        isaretli, bolunen_neg, bolen_neg;
    logic [31:0] bolunen_mag, bolen_mag;
    logic        sifir_bolen, tasma, kabul, hizli, son_adim;
    logic [31:0] hizli_sonuc;
    logic [32:0] kalan_kay, fark;
    logic        bolum_bit;
    logic [31:0] kalan_yeni, bolum_yeni, bolum_son, kalan_son, son_sonuc;

    // Request decode, fast-path detection and one restoring shift-subtract step
    always_comb begin
        isaretli    = ~bb.islem_i[0];
        bolunen_neg = isaretli & bb.bolunen_i[31];
        bolen_neg   = isaretli & bb.bolen_i[31];
        // 0x8000_0000 negates to itself, which is exactly its unsigned magnitude
        bolunen_mag = bolunen_neg ? (32'd0 - bb.bolunen_i) : bb.bolunen_i;
        bolen_mag   = bolen_neg   ? (32'd0 - bb.bolen_i)   : bb.bolen_i;

        sifir_bolen = (bb.bolen_i == 32'd0);
        tasma       = isaretli && (bb.bolunen_i == 32'h8000_0000) && (bb.bolen_i == 32'hFFFF_FFFF);
        kabul       = (durum_q == BOSTA) && bb.istek_i && !bb.iptal_i;
        hizli       = kabul && (sifir_bolen || tasma);

        hizli_sonuc = 32'd0;
        if (sifir_bolen)
            hizli_sonuc = bb.islem_i[1] ? bb.bolunen_i : 32'hFFFF_FFFF;
        else if (tasma)
            hizli_sonuc = bb.islem_i[1] ? 32'd0 : 32'h8000_0000;

        kalan_kay  = {kalan_q, bolum_q[31]};
        fark       = kalan_kay - {1'b0, bolen_q};
        bolum_bit  = ~fark[32];
        kalan_yeni = bolum_bit ? fark[31:0] : kalan_kay[31:0];
        bolum_yeni = {bolum_q[30:0], bolum_bit};

        // Sign flags are only ever set for signed ops, so unsigned results pass untouched
        bolum_son  = (bolunen_neg_q ^ bolen_neg_q) ? (32'd0 - bolum_yeni) : bolum_yeni;
        kalan_son  = bolunen_neg_q ? (32'd0 - kalan_yeni) : kalan_yeni;
        son_sonuc  = kalan_sec_q ? kalan_son : bolum_son;

        son_adim   = (durum_q == HESAPLA) && (sayac_q == 6'd31);
    end

    // Next-state logic: special cases finish without leaving idle, flush always wins
    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOSTA:   if (kabul && !hizli) durum_d = HESAPLA;
            HESAPLA: if (bb.iptal_i || son_adim) durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) durum_q <= BOSTA;
        else        durum_q <= durum_d;
    end

    // Operand capture, iteration datapath and result/valid registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            kalan_sec_q   <= 1'b0;
            bolum_q       <= 32'd0;
            bolen_q       <= 32'd0;
            kalan_q       <= 32'd0;
            sayac_q       <= 6'd0;
            bolunen_neg_q <= 1'b0;
            bolen_neg_q   <= 1'b0;
            sonuc_q       <= 32'd0;
            gecerli_q     <= 1'b0;
        end else begin
            gecerli_q <= 1'b0;
            if (kabul) begin
                kalan_sec_q   <= bb.islem_i[1];
                bolum_q       <= bolunen_mag;
                bolen_q       <= bolen_mag;
                kalan_q       <= 32'd0;
                sayac_q       <= 6'd0;
                bolunen_neg_q <= bolunen_neg;
                bolen_neg_q   <= bolen_neg;
                if (hizli) begin
                    sonuc_q   <= hizli_sonuc;
                    gecerli_q <= 1'b1;
                end
            end else if ((durum_q == HESAPLA) && !bb.iptal_i) begin
                kalan_q <= kalan_yeni;
                bolum_q <= bolum_yeni;
                sayac_q <= sayac_q + 6'd1;
                if (son_adim) begin
                    sonuc_q   <= son_sonuc;
                    gecerli_q <= 1'b1;
                end
            end
        end
    end

    assign bb.sonuc_o   = sonuc_q;
    assign bb.gecerli_o = gecerli_q;
    assign bb.mesgul_o  = (durum_q == HESAPLA);
endmodule
